// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND display controller: mode codes,
// FSM states, display kinds and active-low 7-segment codes.
package fnd_pkg;

   typedef enum logic [1:0] {
      MODE_WATCH     = 2'b00,
      MODE_STOPWATCH = 2'b01,
      MODE_DIST      = 2'b10,
      MODE_DHT       = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_LOAD
   } state_e;

   // KIND_NONE is the post-reset buffer: plain digits, no dp, no blanking.
   typedef enum logic [1:0] {
      KIND_NONE,
      KIND_TIME,
      KIND_DIST,
      KIND_DHT
   } disp_kind_e;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

   // Two-digit BCD view of a converted byte; anything >= 100 shows 99.
   function automatic logic [7:0] sat99(input logic [15:0] bcd);
      return (bcd[15:8] != 8'h00) ? 8'h99 : bcd[7:0];
   endfunction

endpackage

// File: rtl/fnd_display_ctrl_if.sv
// Producer/display bus for the FND controller: mode-muxed word, strobe, page
// select in; busy and the multiplexed digit/segment drives out.
interface fnd_display_ctrl_if;
   logic [1:0]  sel;
   logic [23:0] fnd_bcd;
   logic        upd;
   logic        page;
   logic        busy;
   logic [3:0]  fnd_com;
   logic [7:0]  fnd_data;

   modport master (output sel, fnd_bcd, upd, page, input  busy, fnd_com, fnd_data);
   modport slave  (input  sel, fnd_bcd, upd, page, output busy, fnd_com, fnd_data);
endinterface

// File: rtl/fnd_display_ctrl_bin2bcd_seq.sv
// Sequential 10-bit binary to 4-digit BCD converter (shift-add-3). The start
// edge performs the first shift, so ten edges in total produce the result.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [9:0]  i_bin,
   output logic        o_done,
   output logic [15:0] o_bcd
);

   logic [15:0] r_bcd;
   logic [9:0]  r_bin;
   logic [3:0]  r_cnt;
   logic [15:0] w_adj;

   // NOTE: w_adj takes a full default before the per-digit overrides, so no latch is inferred.
   always_comb begin
      w_adj = r_bcd;
      for (int k = 0; k < 4; k++) begin
         if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd <= '0;
         r_bin <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_bcd <= {15'd0, i_bin[9]};
         r_bin <= {i_bin[8:0], 1'b0};
         r_cnt <= 4'd9;
      end else if (r_cnt != 4'd0) begin
         r_bcd <= {w_adj[14:0], r_bin[9]};
         r_bin <= {r_bin[8:0], 1'b0};
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // High during the cycle whose closing edge performs the final shift.
   assign o_done = (r_cnt == 4'd1);
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/fnd_display_ctrl.sv
// FND display controller: captures the mode-muxed word, converts binary modes
// to BCD and scans four common-anode digits. Option macro: LEADING_ZERO_BLANK_EN.
module fnd_display_ctrl
   import fnd_pkg::*;
#(
   parameter int SCAN_DIV     = 100_000,
   parameter int DP_BLINK_DIV = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   fnd_display_ctrl_if.slave bus
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(DP_BLINK_DIV);

   state_e           r_state;
   mode_e            r_mode;
   logic [23:0]      r_word;
   logic             r_busy;
   logic             r_start;
   logic             r_phase_t;
   logic [7:0]       r_rh;
   logic [23:0]      r_buf;
   disp_kind_e       r_kind;
   logic [SCAN_W-1:0]  r_scan_cnt;
   logic [1:0]         r_idx;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic             r_blink;
   logic [3:0]       r_com;
   logic [7:0]       r_data;

   logic             w_conv_done;
   logic [15:0]      w_conv_bcd;
   logic [9:0]       w_conv_bin;
   logic [2:0]       w_pos;
   logic [3:0]       w_nib;
   logic [7:0]       w_seg;

   assign w_conv_bin = (r_mode == MODE_DIST) ? r_word[9:0]
                     : {2'b00, (r_phase_t ? r_word[7:0] : r_word[15:8])};

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (r_start),
      .i_bin   (w_conv_bin),
      .o_done  (w_conv_done),
      .o_bcd   (w_conv_bcd)
   );

   // NOTE: the display buffer is reset too, so a job aborted by reset leaves 0000, never a partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_mode    <= MODE_WATCH;
         r_word    <= '0;
         r_busy    <= 1'b0;
         r_start   <= 1'b0;
         r_phase_t <= 1'b0;
         r_rh      <= '0;
         r_buf     <= '0;
         r_kind    <= KIND_NONE;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.upd) begin
                  r_mode    <= mode_e'(bus.sel);
                  r_word    <= bus.fnd_bcd;
                  r_busy    <= 1'b1;
                  r_phase_t <= 1'b0;
                  if (bus.sel[1]) begin
                     r_start <= 1'b1;
                     r_state <= ST_CONV;
                  end else begin
                     r_state <= ST_LOAD;
                  end
               end
            end
            ST_CONV: begin
               // The t conversion starts on the edge that still sees the rh result.
               if (r_start && r_phase_t) r_rh <= sat99(w_conv_bcd);
               if (w_conv_done) begin
                  if (r_mode == MODE_DHT && !r_phase_t) begin
                     r_phase_t <= 1'b1;
                     r_start   <= 1'b1;
                  end else begin
                     r_state <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
               case (r_mode)
                  MODE_DIST: begin
                     r_buf  <= {8'h00, w_conv_bcd};
                     r_kind <= KIND_DIST;
                  end
                  MODE_DHT: begin
                     r_buf  <= {8'h00, r_rh, sat99(w_conv_bcd)};
                     r_kind <= KIND_DHT;
                  end
                  default: begin
                     r_buf  <= r_word;
                     r_kind <= KIND_TIME;
                  end
               endcase
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_pos = {1'b0, r_idx};
      if (r_kind == KIND_TIME && bus.page) w_pos = w_pos + 3'd2;
      w_nib = r_buf[{w_pos, 2'b00} +: 4];
      w_seg = seg_of(w_nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (r_kind == KIND_DIST) begin
         case (r_idx)
            2'd3:    if (r_buf[15:12] == 4'd0) w_seg = SEG_BLANK;
            2'd2:    if (r_buf[15:8]  == 8'd0) w_seg = SEG_BLANK;
            2'd1:    if (r_buf[15:4]  == 12'd0) w_seg = SEG_BLANK;
            default: ;
         endcase
      end
`endif
      if (r_idx == 2'd2 && ((r_kind == KIND_TIME && r_blink) || r_kind == KIND_DHT))
         w_seg[7] = 1'b0;
   end

   // Digit enable and segments come from the same r_idx on the same edge: no ghosting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt  <= '0;
         r_idx       <= 2'd0;
         r_blink_cnt <= '0;
         r_blink     <= 1'b1;
         r_com       <= 4'b1110;
         r_data      <= SEG_0;
      end else begin
         if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         if (r_blink_cnt == BLINK_W'(DP_BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
         r_com  <= ~(4'b0001 << r_idx);
         r_data <= w_seg;
      end
   end

   assign bus.busy     = r_busy;
   assign bus.fnd_com  = r_com;
   assign bus.fnd_data = r_data;

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// Directed bench for fnd_display_ctrl with shortened scan/blink dividers;
// expected segment codes are hand-computed per digit.
module tb_fnd_display_ctrl;

   localparam int SCAN_DIV     = 4;
   localparam int DP_BLINK_DIV = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   fnd_display_ctrl_if bus ();

   fnd_display_ctrl #(
      .SCAN_DIV     (SCAN_DIV),
      .DP_BLINK_DIV (DP_BLINK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic read_slot(input int idx, output logic [7:0] d);
      logic [3:0] oh;
      bit         found;
      oh    = 4'b0001 << idx;
      found = 1'b0;
      d     = 8'h00;
      for (int i = 0; i < 8*SCAN_DIV && !found; i++) begin
         @(negedge clk);
         if (bus.fnd_com == ~oh) begin
            d     = bus.fnd_data;
            found = 1'b1;
         end
      end
      if (!found) check("slot_timeout", 32'(idx), 32'hFFFF_FFFF);
   endtask

   // Digit 2 may carry the blinking dp; blink2 masks bit 7 for that slot.
   task automatic check_slots(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input bit blink2);
      logic [7:0] d;
      repeat (2) @(negedge clk);
      read_slot(0, d); check({tag, "_d0"}, 32'(d), 32'(e0));
      read_slot(1, d); check({tag, "_d1"}, 32'(d), 32'(e1));
      read_slot(2, d); if (blink2) d = d | 8'h80;
      check({tag, "_d2"}, 32'(d), 32'(e2));
      read_slot(3, d); check({tag, "_d3"}, 32'(d), 32'(e3));
   endtask

   task automatic do_job(input logic [1:0] sel, input logic [23:0] word, output int cyc);
      @(negedge clk);
      bus.sel     = sel;
      bus.fnd_bcd = word;
      bus.upd     = 1'b1;
      @(negedge clk);
      bus.upd = 1'b0;
      cyc     = 0;
      while (bus.busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc;
      bit         seen_on, seen_off;
      logic [7:0] blank;

`ifdef LEADING_ZERO_BLANK_EN
      blank = 8'hFF;
`else
      blank = 8'hC0;
`endif

      bus.sel     = 2'b00;
      bus.fnd_bcd = '0;
      bus.upd     = 1'b0;
      bus.page    = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_com",  32'(bus.fnd_com),  32'h0E);
      check("rst_data", 32'(bus.fnd_data), 32'hC0);
      check("rst_busy", 32'(bus.busy),     32'h0);
      rst_n = 1'b1;
      check_slots("rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);

      // Watch mode, both pages, blink observation on digit 2
      do_job(2'b00, 24'h123456, cyc);
      check("watch_busy", 32'(cyc), 32'd1);
      check_slots("watch_p0", 8'h82, 8'h92, 8'h99, 8'hB0, 1'b1);
      seen_on  = 1'b0;
      seen_off = 1'b0;
      for (int i = 0; i < 4*DP_BLINK_DIV; i++) begin
         @(negedge clk);
         if (bus.fnd_com == 4'b1011) begin
            if (bus.fnd_data == 8'h19) seen_on  = 1'b1;
            if (bus.fnd_data == 8'h99) seen_off = 1'b1;
         end
      end
      check("watch_blink", {30'd0, seen_on, seen_off}, 32'd3);
      bus.page = 1'b1;
      check_slots("watch_p1", 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1);
      bus.page = 1'b0;

      // Stopwatch mode
      do_job(2'b01, 24'h000359, cyc);
      check_slots("sw", 8'h90, 8'h92, 8'hB0, 8'hC0, 1'b1);

      // Distance mode
      do_job(2'b10, 24'd1023, cyc);
      check("dist_busy", 32'(cyc), 32'd11);
      check_slots("dist1023", 8'hB0, 8'hA4, 8'hC0, 8'hF9, 1'b0);
      do_job(2'b10, 24'd7, cyc);
      check_slots("dist7", 8'hF8, blank, blank, blank, 1'b0);
      bus.page = 1'b1;
      check_slots("dist7_pg", 8'hF8, blank, blank, blank, 1'b0);
      bus.page = 1'b0;

      // DHT mode, including saturation of a three-digit value
      do_job(2'b11, {8'd0, 8'd45, 8'd123}, cyc);
      check("dht_busy", 32'(cyc), 32'd21);
      check_slots("dht45_123", 8'h90, 8'h90, 8'h12, 8'h99, 1'b0);
      do_job(2'b11, {8'd0, 8'd100, 8'd0}, cyc);
      check_slots("dht100_0", 8'hC0, 8'hC0, 8'h10, 8'h90, 1'b0);

      // upd during a distance job is dropped
      @(negedge clk);
      bus.sel     = 2'b10;
      bus.fnd_bcd = 24'd512;
      bus.upd     = 1'b1;
      @(negedge clk);
      bus.upd = 1'b0;
      cyc     = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy) cyc++;
         if (i == 4) begin
            bus.sel     = 2'b00;
            bus.fnd_bcd = 24'hFFFFFF;
         end
         bus.upd = (i == 4);
         @(negedge clk);
      end
      check("drop_busy", 32'(cyc), 32'd11);
      check("drop_idle", 32'(bus.busy), 32'd0);
      check_slots("drop512", 8'hA4, 8'hF9, 8'h92, blank, 1'b0);

      // Reset in the middle of a conversion
      @(negedge clk);
      bus.sel     = 2'b10;
      bus.fnd_bcd = 24'd1023;
      bus.upd     = 1'b1;
      @(negedge clk);
      bus.upd = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      check_slots("abort", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);

      // Invalid BCD nibble shows a dash
      do_job(2'b00, 24'h9876A5, cyc);
      check_slots("dash", 8'h92, 8'hBF, 8'h82, 8'hF8, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
